// File: rtl/uart_pkg.sv
// Shared UART definitions: register bit positions and receiver state encoding.
// The transmit block uses the same package so both share one register map.
package uart_pkg;

  localparam int STAT_VALID     = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_BUSY      = 3;

  localparam int CTRL_ACK       = 0;
  localparam int CTRL_CLR_ERR   = 1;
  localparam int CTRL_RX_EN     = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_line_sync.sv
// Two-flop synchronizer (resets to 1) with a registered falling-edge detect.
// A fall is reported only once a genuine high sample has passed through after reset.
module uart_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic fall
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [1:0] fill;

  // fill marks when s2 holds a real sample rather than its reset value, so a
  // line held low through reset release cannot look like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b0;
      fill <= 2'b00;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
      prev <= s2 & fill[1];
    end
  end

  assign level = s2;
  assign fall  = prev & ~s2;

endmodule

// File: rtl/uart_rx_block.sv
// 8N1 UART receiver presenting each byte on a DATA register with a STATUS byte.
//
// state    | meaning
// RX_IDLE  | waiting for a start edge while enabled
// RX_START | counting to the middle of the start bit to confirm it
// RX_DATA  | sampling 8 data bits, LSB first, one per bit period
// RX_STOP  | sampling the stop bit; commit byte or flag a framing error
// RX_BREAK | line held low after a framing error; wait for it to go high
module uart_rx_block
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_in,
  input  logic [7:0] control,
  output logic [7:0] data,
  output logic [7:0] status
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state;
  rx_state_e     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic [7:0]    data_n;
  logic          valid;
  logic          valid_n;
  logic          overrun;
  logic          overrun_n;
  logic          frame_err;
  logic          frame_err_n;
  logic          busy;
  logic          level;
  logic          fall;

  logic ack;
  logic clr_err;
  logic rx_en;
  logic unused_ctrl;

  assign ack         = control[CTRL_ACK];
  assign clr_err     = control[CTRL_CLR_ERR];
  assign rx_en       = control[CTRL_RX_EN];
  assign unused_ctrl = ^control[6:2];

  uart_line_sync u_line_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (line_in),
    .level    (level),
    .fall     (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      overrun   <= overrun_n;
      frame_err <= frame_err_n;
      busy      <= (state_n != RX_IDLE);
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    data_n      = data;
    valid_n     = valid;
    overrun_n   = overrun;
    frame_err_n = frame_err;

    // clears are applied first so that a same-edge completion or error wins
    if (clr_err) begin
      overrun_n   = 1'b0;
      frame_err_n = 1'b0;
    end
    if (ack) valid_n = 1'b0;

    if (state != RX_IDLE && !rx_en) begin
      state_n   = RX_IDLE;
      cnt_n     = '0;
      bit_idx_n = 3'd0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (rx_en && fall) begin
            state_n = RX_START;
            cnt_n   = '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_TC) begin
            cnt_n     = '0;
            bit_idx_n = 3'd0;
            state_n   = level ? RX_IDLE : RX_DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_TC) begin
            cnt_n            = '0;
            shift_n[bit_idx] = level;
            if (bit_idx == 3'd7) begin
              bit_idx_n = 3'd0;
              state_n   = RX_STOP;
            end else begin
              bit_idx_n = bit_idx + 3'd1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_TC) begin
            cnt_n = '0;
            if (level) begin
              data_n = shift;
              if (valid && !ack) overrun_n = 1'b1;
              valid_n = 1'b1;
              state_n = RX_IDLE;
            end else begin
              frame_err_n = 1'b1;
              state_n     = RX_BREAK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          if (level) state_n = RX_IDLE;
        end
        default: state_n = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    status                 = 8'h00;
    status[STAT_VALID]     = valid;
    status[STAT_OVERRUN]   = overrun;
    status[STAT_FRAME_ERR] = frame_err;
    status[STAT_BUSY]      = busy;
  end

endmodule

// File: tb/tb_uart_rx_block.sv
// Directed bench for uart_rx_block: serial frames are generated here, expected
// bytes go into a scoreboard queue and are popped when the receiver commits.
module tb_uart_rx_block;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_in;
  logic [7:0] control;
  logic [7:0] data;
  logic [7:0] status;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  logic [7:0] b5;

  always #5 clk = ~clk;

  uart_rx_block #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .line_in (line_in),
    .control (control),
    .data    (data),
    .status  (status)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard, expected a queued byte", tag);
    end else begin
      check(tag, data, sb.pop_front());
    end
  endtask

  // one bit period: line changes just after a rising edge, held CPB cycles
  task automatic drive_bit(input logic b);
    @(posedge clk);
    #1 line_in = b;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) sb.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic pulse_control(input logic [7:0] c);
    @(posedge clk);
    #1 control = c;
    @(posedge clk);
    #1 control = 8'h80;
  endtask

  initial begin
    logic [7:0] b1;
    logic [7:0] b6;
    rst     = 1'b1;
    line_in = 1'b0;
    control = 8'h80;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_status", status, 8'h00);
    check("reset_data", data, 8'h00);
    rst = 1'b0;

    // line held low through reset release must not start a frame
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("low_at_release", status, 8'h00);
    line_in = 1'b1;
    repeat (5) @(posedge clk);

    // 1: single byte with exact commit timing and BUSY across the frame
    b1 = 8'h4E;
    sb.push_back(b1);
    drive_bit(1'b0);
    @(negedge clk);
    check("t1_busy_start", status, 8'h08);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b1[i]);
      @(negedge clk);
      check("t1_busy_data", status, 8'h08);
    end
    @(posedge clk);
    #1 line_in = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t1_pre_commit", status, 8'h08);
    @(posedge clk);
    @(negedge clk);
    check("t1_status", status, 8'h01);
    check_sb("t1_data");
    repeat (4) @(posedge clk);
    pulse_control(8'h81);
    @(negedge clk);
    check("t1_ack", status, 8'h00);

    // 2: back-to-back frames without ACK produce overrun
    send_frame(8'h55, 1'b1);
    @(negedge clk);
    check("t2_first_status", status, 8'h01);
    check_sb("t2_first_data");
    send_frame(8'hAA, 1'b1);
    @(negedge clk);
    check("t2_overrun_status", status, 8'h03);
    check_sb("t2_second_data");
    pulse_control(8'h82);
    @(negedge clk);
    check("t2_clr_err", status, 8'h01);
    pulse_control(8'h81);
    @(negedge clk);
    check("t2_ack", status, 8'h00);

    // 3: framing error, break hold, recovery
    send_frame(8'h3C, 1'b0);
    @(negedge clk);
    check("t3_frame_err", status, 8'h0C);
    check("t3_data_kept", data, 8'hAA);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t3_break_busy", status, 8'h0C);
    @(posedge clk);
    #1 line_in = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t3_break_exit", status, 8'h04);
    send_frame(8'h3C, 1'b1);
    @(negedge clk);
    check("t3_recover_status", status, 8'h05);
    check_sb("t3_recover_data");
    pulse_control(8'h83);
    @(negedge clk);
    check("t3_cleared", status, 8'h00);

    // 4: short low glitch is rejected at the start-bit midpoint
    @(posedge clk);
    #1 line_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 line_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t4_glitch_busy", status, 8'h08);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t4_glitch_status", status, 8'h00);
    check("t4_glitch_data", data, 8'h3C);

    // 5: asynchronous reset during data bit 4, then a clean frame
    b5 = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b5[i]);
    @(posedge clk);
    #1 line_in = b5[4];
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t5_busy_before_rst", status, 8'h08);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_status", status, 8'h00);
    check("t5_rst_data", data, 8'h00);
    line_in = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    send_frame(8'h81, 1'b1);
    @(negedge clk);
    check("t5_after_status", status, 8'h01);
    check_sb("t5_after_data");
    pulse_control(8'h81);
    @(negedge clk);
    check("t5_ack", status, 8'h00);

    // 6: ACK on the very edge a second byte completes
    send_frame(8'h77, 1'b1);
    @(negedge clk);
    check("t6_first_status", status, 8'h01);
    check_sb("t6_first_data");
    b6 = 8'h12;
    sb.push_back(b6);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b6[i]);
    @(posedge clk);
    #1 line_in = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t6_pre_commit", status, 8'h09);
    control = 8'h81;
    @(posedge clk);
    #1 control = 8'h80;
    @(negedge clk);
    check("t6_status", status, 8'h01);
    check_sb("t6_data");
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
